pipe_skid_stage: RTL

- Parametrised, handshaked pipeline stage register; the successor to the fixed-width stall/flush stage registers between IF/ID, ID/EX, and so on.
- Replaces the global stall with a per-stage valid/ready handshake.
- A 2-entry skid buffer keeps in_ready a pure register output, so no combinational ready path crosses stages.
- Empty slots present a configurable bubble (NOP) encoding. Two saturating counters record stall and flush events for performance debug.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_skid_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for handshaked pipeline stages.
// Imported by every stage register in the core.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'hFFFF;
  localparam int          PC_RESET          = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter for stage performance debug.
// Counts once per cycle with inc=1 and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = (count == {W{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Handshaked pipeline register with a 2-entry skid buffer.
// in_ready decodes only the state register, never out_ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = 16,
  parameter int                 PC_W      = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  state_t state_q;
  state_t state_d;

  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    main_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;

  logic acc;
  logic deq;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic stall_inc;
  logic flush_inc;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign acc       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          unique case (1'b1)
            acc && !deq: begin
              state_d   = FULL;
              load_skid = 1'b1;
            end
            acc && deq: begin
              load_main_in = 1'b1;
            end
            !acc && deq: begin
              state_d = EMPTY;
            end
            default: begin
            end
          endcase
        end
        FULL: begin
          if (deq) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_instr <= NOP_INSTR;
      main_pc    <= PC_W'(PC_RESET);
      skid_instr <= NOP_INSTR;
      skid_pc    <= PC_W'(PC_RESET);
    end else begin
      if (load_main_in) begin
        main_instr <= in_instr;
        main_pc    <= in_pc;
      end else if (load_main_skid) begin
        main_instr <= skid_instr;
        main_pc    <= skid_pc;
      end
      if (load_skid) begin
        skid_instr <= in_instr;
        skid_pc    <= in_pc;
      end
    end
  end

  // Empty head shows a bubble whatever the slot still holds
  assign out_instr = out_valid ? main_instr : NOP_INSTR;
  assign out_pc    = out_valid ? main_pc : PC_W'(PC_RESET);

  assign stall_inc = out_valid & ~out_ready;
  assign flush_inc = flush & (out_valid | acc);

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (stall_inc),
    .count  (stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (flush_inc),
    .count  (flush_cnt)
  );

endmodule
